drive_cmd_arbiter: RTL and testbench

Consumes the debounced one-pulse button commands (forward/backward/left/right, auto/dance mode toggles) and arbitrates motor control between three sources: manual pulses, the autonomous driver's direction requests, and an internal dance pattern sequencer. It enforces a brake (STOP) interval on every direction reversal or mode change while moving, then drives registered left/right motor direction codes. It sits between the button conditioning stage and the motor driver (H-bridge) block.

---
 rtl/car_pkg.sv | 55 +++++
 rtl/drive_timer.sv | 26 ++
 rtl/drive_cmd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_drive_cmd_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared encodings for the drive command path: modes, motions, motor codes,
// arbiter states and the dance choreography.
package car_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'd0,
      MODE_AUTO   = 2'd1,
      MODE_DANCE  = 2'd2
   } mode_t;

   typedef enum logic [2:0] {
      MOT_STOP  = 3'd0,
      MOT_FWD   = 3'd1,
      MOT_BWD   = 3'd2,
      MOT_LEFT  = 3'd3,
      MOT_RIGHT = 3'd4
   } motion_t;

   typedef enum logic [1:0] {
      MTR_STOP = 2'b00,
      MTR_FWD  = 2'b01,
      MTR_BWD  = 2'b10
   } motor_t;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_AUTO   = 2'd1,
      ST_DANCE  = 2'd2,
      ST_BRAKE  = 2'd3
   } state_t;

   // Index 0 is the first step: FWD, LEFT, BWD, RIGHT, FWD, RIGHT, BWD, LEFT.
   localparam logic [7:0][2:0] DANCE_PATTERN = {
      3'd3, 3'd2, 3'd4, 3'd1, 3'd4, 3'd2, 3'd3, 3'd1
   };

   function automatic motion_t decode_auto(input logic [2:0] code);
      case (code)
         3'd1:    return MOT_FWD;
         3'd2:    return MOT_BWD;
         3'd3:    return MOT_LEFT;
         3'd4:    return MOT_RIGHT;
         default: return MOT_STOP;
      endcase
   endfunction

   function automatic state_t state_of(input mode_t m);
      case (m)
         MODE_AUTO:  return ST_AUTO;
         MODE_DANCE: return ST_DANCE;
         default:    return ST_MANUAL;
      endcase
   endfunction

endpackage

// File: rtl/drive_timer.sv
// Loadable down-counter that saturates at zero; shared by hold, brake and
// dance-step timing.
module drive_timer #(
   parameter int CNT_W = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic [CNT_W-1:0] value,
   output logic             expired
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (value != '0) begin
         value <= value - 1'b1;
      end
   end

   assign expired = (value == '0);

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Arbitrates manual pulses, autonomous requests and the dance sequencer onto
// registered motor direction codes, inserting a STOP interval on reversals.
module drive_cmd_arbiter
   import car_pkg::*;
#(
   parameter int HOLD_CYCLES       = 25000000,
   parameter int DANCE_STEP_CYCLES = 50000000,
   parameter int BRAKE_CYCLES      = 5000000,
   parameter int CNT_W             = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       forward_op,
   input  logic       backward_op,
   input  logic       left_op,
   input  logic       right_op,
   input  logic       auto_mode_signal_op,
   input  logic       dance_mode_signal_op,
   input  logic       auto_dir_valid,
   input  logic [2:0] auto_dir,
   output logic [1:0] mode,
   output logic [2:0] motion,
   output logic [1:0] motor_left,
   output logic [1:0] motor_right,
   output logic       busy
);

   // Timer is loaded with N-1 so that the expiry cycle is the Nth cycle.
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DANCE_LOAD = CNT_W'(DANCE_STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] BRAKE_LOAD = CNT_W'(BRAKE_CYCLES - 1);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d, pend_mode_q, pend_mode_d;
   mode_t            base_mode, req_mode, apply_mode;
   motion_t          motion_q, motion_d, pend_motion_q, pend_motion_d;
   motion_t          req_motion, apply_motion;
   logic [2:0]       step_q, step_d, step_nxt;
   logic             req_valid, reversal, do_apply;
   logic             tmr_load, tmr_expired;
   logic [CNT_W-1:0] tmr_load_value, timer_count_unused;
   logic [1:0]       motor_left_q, motor_right_q, motor_left_d, motor_right_d;
   logic             busy_q;

   drive_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (tmr_load),
      .load_value (tmr_load_value),
      .value      (timer_count_unused),
      .expired    (tmr_expired)
   );

   // During a brake, requests are judged against the pending mode, not the
   // mode still shown on the outputs.
   always_comb begin
      base_mode  = (state_q == ST_BRAKE) ? pend_mode_q : mode_q;
      req_valid  = 1'b1;
      req_mode   = base_mode;
      req_motion = MOT_STOP;
      if (auto_mode_signal_op) begin
         req_mode = (base_mode == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
      end else if (dance_mode_signal_op) begin
         req_mode   = (base_mode == MODE_DANCE) ? MODE_MANUAL : MODE_DANCE;
         req_motion = (req_mode == MODE_DANCE) ? motion_t'(DANCE_PATTERN[0]) : MOT_STOP;
      end else if (base_mode == MODE_MANUAL &&
                   (forward_op || backward_op || left_op || right_op)) begin
         if (forward_op)       req_motion = MOT_FWD;
         else if (backward_op) req_motion = MOT_BWD;
         else if (left_op)     req_motion = MOT_LEFT;
         else                  req_motion = MOT_RIGHT;
      end else if (base_mode == MODE_AUTO && auto_dir_valid) begin
         req_motion = decode_auto(auto_dir);
      end else begin
         req_valid = 1'b0;
      end
   end

   always_comb begin
      state_d        = state_q;
      mode_d         = mode_q;
      motion_d       = motion_q;
      pend_mode_d    = pend_mode_q;
      pend_motion_d  = pend_motion_q;
      step_d         = step_q;
      step_nxt       = step_q + 3'd1;
      tmr_load       = 1'b0;
      tmr_load_value = '0;
      do_apply       = 1'b0;
      apply_mode     = req_mode;
      apply_motion   = req_motion;
      reversal       = (motion_q == MOT_FWD && req_motion == MOT_BWD) ||
                       (motion_q == MOT_BWD && req_motion == MOT_FWD);

      if (state_q == ST_BRAKE) begin
         if (req_valid) begin
            pend_mode_d   = req_mode;
            pend_motion_d = req_motion;
         end
         if (tmr_expired) begin
            do_apply     = 1'b1;
            apply_mode   = pend_mode_d;
            apply_motion = pend_motion_d;
         end
      end else if (req_valid) begin
         if ((req_mode != mode_q && motion_q != MOT_STOP) || reversal) begin
            state_d        = ST_BRAKE;
            pend_mode_d    = req_mode;
            pend_motion_d  = req_motion;
            motion_d       = MOT_STOP;
            tmr_load       = 1'b1;
            tmr_load_value = BRAKE_LOAD;
         end else begin
            do_apply = 1'b1;
         end
      end else if (state_q == ST_MANUAL) begin
         if (motion_q != MOT_STOP && tmr_expired) motion_d = MOT_STOP;
      end else if (state_q == ST_DANCE) begin
         if (tmr_expired) begin
            step_d         = step_nxt;
            motion_d       = motion_t'(DANCE_PATTERN[step_nxt]);
            tmr_load       = 1'b1;
            tmr_load_value = DANCE_LOAD;
         end
      end

      if (do_apply) begin
         state_d  = state_of(apply_mode);
         mode_d   = apply_mode;
         motion_d = apply_motion;
         if (apply_mode == MODE_MANUAL && apply_motion != MOT_STOP) begin
            tmr_load       = 1'b1;
            tmr_load_value = HOLD_LOAD;
         end else if (apply_mode == MODE_DANCE) begin
            step_d         = 3'd0;
            tmr_load       = 1'b1;
            tmr_load_value = DANCE_LOAD;
         end
      end

      case (motion_d)
         MOT_FWD:   begin motor_left_d = MTR_FWD;  motor_right_d = MTR_FWD;  end
         MOT_BWD:   begin motor_left_d = MTR_BWD;  motor_right_d = MTR_BWD;  end
         MOT_LEFT:  begin motor_left_d = MTR_BWD;  motor_right_d = MTR_FWD;  end
         MOT_RIGHT: begin motor_left_d = MTR_FWD;  motor_right_d = MTR_BWD;  end
         default:   begin motor_left_d = MTR_STOP; motor_right_d = MTR_STOP; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_MANUAL;
         mode_q        <= MODE_MANUAL;
         motion_q      <= MOT_STOP;
         pend_mode_q   <= MODE_MANUAL;
         pend_motion_q <= MOT_STOP;
         step_q        <= 3'd0;
         motor_left_q  <= MTR_STOP;
         motor_right_q <= MTR_STOP;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         motion_q      <= motion_d;
         pend_mode_q   <= pend_mode_d;
         pend_motion_q <= pend_motion_d;
         step_q        <= step_d;
         motor_left_q  <= motor_left_d;
         motor_right_q <= motor_right_d;
         busy_q        <= (state_d == ST_BRAKE);
      end
   end

   assign mode        = mode_q;
   assign motion      = motion_q;
   assign motor_left  = motor_left_q;
   assign motor_right = motor_right_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Bench for drive_cmd_arbiter: a time-stamp based reference model predicts
// every output cycle; directed scenarios plus a randomized soak.
module tb_drive_cmd_arbiter;

   localparam int HOLD  = 10;
   localparam int DSTEP = 8;
   localparam int BRAKE = 4;
   localparam int CW    = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fw = 1'b0, bw = 1'b0, lf = 1'b0, rt = 1'b0, am = 1'b0, dm = 1'b0;
   logic       adv = 1'b0;
   logic [2:0] adir = 3'd0;
   logic [1:0] mode, ml, mr;
   logic [2:0] motion;
   logic       busy;

   drive_cmd_arbiter #(
      .HOLD_CYCLES(HOLD), .DANCE_STEP_CYCLES(DSTEP), .BRAKE_CYCLES(BRAKE), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .forward_op(fw), .backward_op(bw), .left_op(lf), .right_op(rt),
      .auto_mode_signal_op(am), .dance_mode_signal_op(dm),
      .auto_dir_valid(adv), .auto_dir(adir),
      .mode(mode), .motion(motion), .motor_left(ml), .motor_right(mr), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [9:0] exp_q[$];

   // Reference model: absolute cycle stamps instead of counters.
   int m_mode = 0, m_motion = 0, p_mode = 0, p_motion = 0;
   bit m_busy = 0, in_brake = 0;
   int hold_end = 0, brake_apply = 0, dance_start = 0;
   int pattern[8] = '{1, 3, 2, 4, 1, 4, 2, 3};

   task automatic model_apply(input int md, input int mo, input int at);
      m_mode   = md;
      m_motion = mo;
      in_brake = 0;
      if (md == 0 && mo != 0) hold_end = at + HOLD - 1;
      if (md == 2) dance_start = at;
   endtask

   task automatic model_step();
      int bm, rm, rmo, nxt;
      bit has, rev;
      if (rst) begin
         m_mode = 0; m_motion = 0; m_busy = 0; in_brake = 0; p_mode = 0; p_motion = 0;
         return;
      end
      nxt = cyc + 1;
      bm  = in_brake ? p_mode : m_mode;
      has = 1; rm = bm; rmo = 0;
      if (am) rm = (bm == 1) ? 0 : 1;
      else if (dm) begin rm = (bm == 2) ? 0 : 2; rmo = (rm == 2) ? 1 : 0; end
      else if (bm == 0 && (fw | bw | lf | rt)) rmo = fw ? 1 : (bw ? 2 : (lf ? 3 : 4));
      else if (bm == 1 && adv) rmo = (adir <= 3'd4) ? int'(adir) : 0;
      else has = 0;
      if (in_brake) begin
         if (has) begin p_mode = rm; p_motion = rmo; end
         if (nxt == brake_apply) model_apply(p_mode, p_motion, nxt);
      end else if (has) begin
         rev = (m_motion == 1 && rmo == 2) || (m_motion == 2 && rmo == 1);
         if ((rm != m_mode && m_motion != 0) || rev) begin
            in_brake = 1; brake_apply = nxt + BRAKE; p_mode = rm; p_motion = rmo; m_motion = 0;
         end else begin
            model_apply(rm, rmo, nxt);
         end
      end else if (m_mode == 0) begin
         if (m_motion != 0 && nxt > hold_end) m_motion = 0;
      end else if (m_mode == 2) begin
         m_motion = pattern[((nxt - dance_start) / DSTEP) % 8];
      end
      m_busy = in_brake;
   endtask

   function automatic logic [9:0] exp_vec();
      logic [3:0] lr;
      case (m_motion)
         1:       lr = 4'b0101;
         2:       lr = 4'b1010;
         3:       lr = 4'b1001;
         4:       lr = 4'b0110;
         default: lr = 4'b0000;
      endcase
      return {2'(m_mode), 3'(m_motion), lr, m_busy};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {mode, motion, ml, mr, busy};
   endfunction

   // Inputs are held from one negedge to the next; model sees what the DUT samples.
   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      exp_q.push_back(exp_vec());
      fw = 0; bw = 0; lf = 0; rt = 0; am = 0; dm = 0; adv = 0;
   endtask

   task automatic test_reset();
      logic [9:0] obs, e;
      rst = 1;
      tick();
      tick();
      void'(exp_q.pop_front());
      obs = dut_vec(); e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_model got=%h want=%h", obs, e); end
      checks++;
      if (obs !== 10'd0) begin errors++; $display("FAIL reset_zero got=%h want=000", obs); end
      rst = 0;
   endtask

   task automatic test_fwd_hold();
      logic [9:0] obs, e;
      fw = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         obs = dut_vec(); e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL fwd_hold cyc=%0d got=%h want=%h", cyc, obs, e); end
         if (i == 0 || i == 9) begin
            checks++;
            if (motion !== 3'd1 || ml !== 2'b01 || mr !== 2'b01 || busy !== 1'b0) begin
               errors++; $display("FAIL fwd_hold_on i=%0d got=%h want=motion 1 motors 01/01", i, obs);
            end
         end
         if (i == 10) begin
            checks++;
            if (motion !== 3'd0) begin errors++; $display("FAIL fwd_hold_off got=%0d want=0", motion); end
         end
      end
   endtask

   task automatic test_reversal();
      logic [9:0] obs, e;
      fw = 1;
      for (int i = 0; i < 19; i++) begin
         if (i == 3) bw = 1;
         tick();
         obs = dut_vec(); e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL reversal cyc=%0d got=%h want=%h", cyc, obs, e); end
         if (i == 3 || i == 6) begin
            checks++;
            if (busy !== 1'b1 || motion !== 3'd0) begin errors++; $display("FAIL reversal_brake i=%0d got=%h want=busy 1 stop", i, obs); end
         end
         if (i == 7) begin
            checks++;
            if (motion !== 3'd2 || ml !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL reversal_bwd got=%h want=motion 2", obs); end
         end
         if (i == 17) begin
            checks++;
            if (motion !== 3'd0) begin errors++; $display("FAIL reversal_end got=%0d want=0", motion); end
         end
      end
   endtask

   task automatic test_left_extend();
      logic [9:0] obs, e;
      lf = 1; rt = 1;
      for (int i = 0; i < 18; i++) begin
         if (i == 5) lf = 1;
         tick();
         obs = dut_vec(); e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL left_extend cyc=%0d got=%h want=%h", cyc, obs, e); end
         if (i == 0 || i == 14) begin
            checks++;
            if (motion !== 3'd3 || ml !== 2'b10 || mr !== 2'b01) begin errors++; $display("FAIL left_on i=%0d got=%h want=motion 3 motors 10/01", i, obs); end
         end
         if (i == 15) begin
            checks++;
            if (motion !== 3'd0) begin errors++; $display("FAIL left_off got=%0d want=0", motion); end
         end
      end
   endtask

   task automatic test_auto();
      logic [9:0] obs, e;
      bit ok, has_c;
      for (int k = 0; k < 16; k++) begin
         case (k)
            0:  begin am = 1; dm = 1; end
            1:  begin adv = 1; adir = 3'd4; end
            2:  begin adv = 1; adir = 3'd6; end
            3:  fw = 1;
            4:  begin adv = 1; adir = 3'd1; end
            5:  begin adv = 1; adir = 3'd2; end
            10: am = 1;
            default: ;
         endcase
         tick();
         obs = dut_vec(); e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL auto cyc=%0d got=%h want=%h", cyc, obs, e); end
         has_c = 1;
         case (k)
            0:  ok = (mode === 2'd1 && motion === 3'd0);
            1:  ok = (motion === 3'd4 && ml === 2'b01 && mr === 2'b10);
            2:  ok = (motion === 3'd0);
            3:  ok = (motion === 3'd0 && mode === 2'd1);
            4:  ok = (motion === 3'd1);
            5:  ok = (busy === 1'b1 && motion === 3'd0);
            9:  ok = (motion === 3'd2 && busy === 1'b0);
            14: ok = (mode === 2'd0 && motion === 3'd0 && busy === 1'b0);
            default: begin ok = 1; has_c = 0; end
         endcase
         if (has_c) begin
            checks++;
            if (!ok) begin errors++; $display("FAIL auto_step k=%0d got=%h", k, obs); end
         end
      end
   endtask

   task automatic test_dance();
      logic [9:0] obs, e;
      dm = 1;
      for (int i = 0; i < 70; i++) begin
         tick();
         obs = dut_vec(); e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL dance cyc=%0d got=%h want=%h", cyc, obs, e); end
         if (i == 0 || i == 64) begin
            checks++;
            if (mode !== 2'd2 || motion !== 3'd1) begin errors++; $display("FAIL dance_fwd i=%0d got=%h want=mode 2 motion 1", i, obs); end
         end
         if (i == 8 || i == 63) begin
            checks++;
            if (motion !== 3'd3) begin errors++; $display("FAIL dance_left i=%0d got=%0d want=3", i, motion); end
         end
      end
      rst = 1;
      tick();
      obs = dut_vec(); e = exp_q.pop_front();
      checks++;
      if (obs !== 10'd0 || obs !== e) begin errors++; $display("FAIL dance_reset got=%h want=000", obs); end
      rst = 0;
   endtask

   task automatic test_brake_overwrite();
      logic [9:0] obs, e;
      int busy_cnt = 0;
      for (int k = 0; k < 9; k++) begin
         case (k)
            0: fw = 1;
            1: bw = 1;
            2: am = 1;
            3: fw = 1;
            6: am = 1;
            7: fw = 1;
            default: ;
         endcase
         tick();
         obs = dut_vec(); e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL brake_ovr cyc=%0d got=%h want=%h", cyc, obs, e); end
         if (busy === 1'b1) busy_cnt++;
         if (k == 5) begin
            checks++;
            if (mode !== 2'd1 || motion !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL brake_ovr_apply got=%h want=mode 1 stop", obs); end
         end
         if (k == 6) begin
            checks++;
            if (mode !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL brake_ovr_modechg got=%h want=mode 0 no brake", obs); end
         end
         if (k == 7) begin
            checks++;
            if (motion !== 3'd1) begin errors++; $display("FAIL brake_ovr_fwd got=%0d want=1", motion); end
         end
      end
      checks++;
      if (busy_cnt != BRAKE) begin errors++; $display("FAIL brake_len got=%0d want=%0d", busy_cnt, BRAKE); end
   endtask

   task automatic test_random();
      logic [9:0] obs, e;
      for (int i = 0; i < 3000; i++) begin
         fw   = ($urandom_range(0, 99) < 8);
         bw   = ($urandom_range(0, 99) < 8);
         lf   = ($urandom_range(0, 99) < 6);
         rt   = ($urandom_range(0, 99) < 6);
         am   = ($urandom_range(0, 99) < 3);
         dm   = ($urandom_range(0, 99) < 3);
         adv  = ($urandom_range(0, 99) < 15);
         adir = 3'($urandom_range(0, 7));
         rst  = ($urandom_range(0, 999) < 3);
         tick();
         obs = dut_vec(); e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, e); end
      end
      rst = 0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fwd_hold();
      test_reversal();
      test_left_extend();
      test_auto();
      test_dance();
      test_brake_overwrite();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
